multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 70 +++++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALU commands,
// datapath mux selects and the instruction funct field layout.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXECR  = 4'd2,
    EXECI  = 4'd3,
    ALUWB  = 4'd4,
    MEMADR = 4'd5,
    MEMRD  = 4'd6,
    MEMWB  = 4'd7,
    MEMWR  = 4'd8,
    BRANCH = 4'd9,
    HALT   = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam int FUNCT_I      = 5;
  localparam int FUNCT_CMD_HI = 4;
  localparam int FUNCT_CMD_LO = 1;
  localparam int FUNCT_SL     = 0;

  typedef struct packed {
    logic       legal;
    logic [1:0] alu;
  } alu_dec_t;

  // CMP shares the SUB datapath; only the write-back behaviour differs.
  function automatic alu_dec_t decode_cmd(input logic [3:0] cmd);
    alu_dec_t d;
    d.legal = 1'b1;
    case (cmd)
      CMD_ADD:          d.alu = ALU_ADD;
      CMD_SUB, CMD_CMP: d.alu = ALU_SUB;
      CMD_AND:          d.alu = ALU_AND;
      CMD_ORR:          d.alu = ALU_OR;
      default: begin
        d.legal = 1'b0;
        d.alu   = ALU_ADD;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory-wait state; timeout is combinational
// in the cycle the count sits at MAX_WAIT with memory still not ready. Saturates, never wraps.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

  logic [W-1:0] count;
  logic         stalled;

  assign stalled = waiting && !ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stalled && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign timeout = stalled && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch/decode/execute/memory/writeback sequencing.
// Fetch-to-fetch 3-5 cycles; memory stalls on memReady=0 until MAX_WAIT, then sticky fault + HALT.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       memReady,
  output logic       memReq,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       PCS,
  output logic       regW,
  output logic       memWriteSrc,
  output logic       flagUpdate,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluControl,
  output logic [1:0] resultSrc,
  output logic [3:0] state,
  output logic       fault
);

  state_t   cur, nxt;
  logic     fault_q, fault_set;
  logic     waiting, timeout;
  logic [3:0] cmd;
  alu_dec_t dec;

  assign cmd     = funct[FUNCT_CMD_HI:FUNCT_CMD_LO];
  assign dec     = decode_cmd(cmd);
  assign waiting = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .ready   (memReady),
    .clear   (nxt != cur),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= FETCH;
      fault_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (fault_set) fault_q <= 1'b1;
    end
  end

  always_comb begin
    nxt       = cur;
    fault_set = 1'b0;
    case (cur)
      FETCH: begin
        if (memReady) nxt = DECODE;
        else if (timeout) begin
          nxt       = HALT;
          fault_set = 1'b1;
        end
      end
      DECODE: begin
        case (op)
          OP_DP:   nxt = funct[FUNCT_I] ? EXECI : EXECR;
          OP_MEM:  nxt = MEMADR;
          OP_BR:   nxt = BRANCH;
          default: nxt = HALT;
        endcase
      end
      EXECR, EXECI: begin
        if (dec.legal) nxt = ALUWB;
        else begin
          nxt       = HALT;
          fault_set = 1'b1;
        end
      end
      ALUWB:  nxt = FETCH;
      MEMADR: nxt = funct[FUNCT_SL] ? MEMRD : MEMWR;
      MEMRD, MEMWR: begin
        if (memReady) nxt = (cur == MEMRD) ? MEMWB : FETCH;
        else if (timeout) begin
          nxt       = HALT;
          fault_set = 1'b1;
        end
      end
      MEMWB:   nxt = FETCH;
      BRANCH:  nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  // Outputs are gated by reset so an abandoned store can never strobe mid-reset.
  always_comb begin
    memReq      = 1'b0;
    adrSrc      = 1'b0;
    irWrite     = 1'b0;
    PCS         = 1'b0;
    regW        = 1'b0;
    memWriteSrc = 1'b0;
    flagUpdate  = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REG;
    aluControl  = ALU_ADD;
    resultSrc   = RES_ALUOUT;
    if (!reset) begin
      case (cur)
        FETCH: begin
          memReq = 1'b1;
          if (memReady) begin
            irWrite   = 1'b1;
            PCS       = 1'b1;
            aluSrcB   = SRCB_FOUR;
            resultSrc = RES_ALU;
          end
        end
        EXECR, EXECI: begin
          if (dec.legal) begin
            aluSrcA    = 1'b1;
            aluSrcB    = (cur == EXECI) ? SRCB_IMM : SRCB_REG;
            aluControl = dec.alu;
          end
        end
        ALUWB: begin
          aluControl = dec.alu;
          regW       = (cmd != CMD_CMP);
          flagUpdate = funct[FUNCT_SL] || (cmd == CMD_CMP);
        end
        MEMADR: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
        end
        MEMRD: begin
          memReq = 1'b1;
          adrSrc = 1'b1;
        end
        MEMWB: begin
          resultSrc = RES_MEM;
          regW      = 1'b1;
        end
        MEMWR: begin
          memReq      = 1'b1;
          adrSrc      = 1'b1;
          memWriteSrc = memReady;
        end
        BRANCH: begin
          aluSrcB   = SRCB_IMM;
          resultSrc = RES_ALU;
          PCS       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = cur;
  assign fault = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each instruction is expanded by a reference model into the per-cycle
// control outputs it must produce; a driver replays the inputs and a monitor checks outputs.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int MAXW = 15;

  logic       clk, reset, memReady;
  logic [1:0] op;
  logic [5:0] funct;
  logic       memReq, adrSrc, irWrite, PCS, regW, memWriteSrc, flagUpdate, aluSrcA, fault;
  logic [1:0] aluSrcB, aluControl, resultSrc;
  logic [3:0] state;

  multicycle_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .memReady(memReady),
    .memReq(memReq), .adrSrc(adrSrc), .irWrite(irWrite), .PCS(PCS), .regW(regW),
    .memWriteSrc(memWriteSrc), .flagUpdate(flagUpdate), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .resultSrc(resultSrc),
    .state(state), .fault(fault)
  );

  typedef struct packed {
    logic       memReq, adrSrc, irWrite, PCS, regW, memWriteSrc, flagUpdate, aluSrcA;
    logic [1:0] aluSrcB, aluControl, resultSrc;
    logic [3:0] state;
    logic       fault;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic [1:0] op;
    logic [5:0] funct;
  } stim_t;

  stim_t      stim_q[$];
  obs_t       exp_q[$];
  logic [1:0] cur_op;
  logic [5:0] cur_funct;
  int         vectors = 0;
  int         miscompares = 0;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t idle(input logic [3:0] st, input logic flt);
    obs_t e = '0;
    e.state = st;
    e.fault = flt;
    return e;
  endfunction

  function automatic void put(input logic r, input logic rdy, input obs_t e);
    stim_t s;
    s.rst = r; s.rdy = rdy; s.op = cur_op; s.funct = cur_funct;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  function automatic void do_reset(input int n);
    for (int i = 0; i < n; i++) put(1'b1, coin(), idle(FETCH, 1'b0));
  endfunction

  function automatic void halt_then_reset(input logic flt);
    int n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) put(1'b0, coin(), idle(HALT, flt));
    do_reset($urandom_range(1, 2));
  endfunction

  // n not-ready cycles in a memory wait state; returns 1 when memory never answered in time.
  function automatic logic waits(input logic [3:0] st, input int n);
    obs_t e;
    for (int i = 0; i < n && i <= MAXW; i++) begin
      e = idle(st, 1'b0);
      e.memReq = 1'b1;
      e.adrSrc = (st != 4'(FETCH));
      put(1'b0, 1'b0, e);
    end
    return n > MAXW;
  endfunction

  function automatic logic alu_map(input logic [3:0] c, output logic [1:0] a);
    a = 2'b00;
    case (c)
      4'b0100: a = 2'b00;
      4'b0010: a = 2'b01;
      4'b0000: a = 2'b10;
      4'b1100: a = 2'b11;
      4'b1010: a = 2'b01;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // One instruction: fetch waits wf, data-memory waits wm, abort = reset during the memory access.
  function automatic void gen(input logic [1:0] o, input logic [5:0] f, input int wf,
                              input int wm, input logic abort);
    obs_t e;
    logic [1:0] a;
    logic ok;
    logic [3:0] c;
    logic [3:0] mst;
    cur_op = o; cur_funct = f; c = f[4:1];
    if (waits(FETCH, wf)) begin halt_then_reset(1'b1); return; end
    e = idle(FETCH, 1'b0);
    e.memReq = 1'b1; e.irWrite = 1'b1; e.PCS = 1'b1; e.aluSrcB = 2'b10; e.resultSrc = 2'b10;
    put(1'b0, 1'b1, e);
    put(1'b0, coin(), idle(DECODE, 1'b0));
    case (o)
      2'b00: begin
        ok = alu_map(c, a);
        e = idle(f[5] ? EXECI : EXECR, 1'b0);
        if (!ok) begin put(1'b0, coin(), e); halt_then_reset(1'b1); return; end
        e.aluSrcA = 1'b1; e.aluSrcB = f[5] ? 2'b01 : 2'b00; e.aluControl = a;
        put(1'b0, coin(), e);
        e = idle(ALUWB, 1'b0);
        e.aluControl = a;
        e.regW       = (c != 4'b1010);
        e.flagUpdate = f[0] | (c == 4'b1010);
        put(1'b0, coin(), e);
      end
      2'b01: begin
        e = idle(MEMADR, 1'b0); e.aluSrcA = 1'b1; e.aluSrcB = 2'b01;
        put(1'b0, coin(), e);
        mst = f[0] ? MEMRD : MEMWR;
        if (abort) begin void'(waits(mst, 1)); do_reset(1); return; end
        if (waits(mst, wm)) begin halt_then_reset(1'b1); return; end
        e = idle(mst, 1'b0); e.memReq = 1'b1; e.adrSrc = 1'b1; e.memWriteSrc = !f[0];
        put(1'b0, 1'b1, e);
        if (f[0]) begin
          e = idle(MEMWB, 1'b0); e.resultSrc = 2'b01; e.regW = 1'b1;
          put(1'b0, coin(), e);
        end
      end
      2'b10: begin
        e = idle(BRANCH, 1'b0); e.aluSrcB = 2'b01; e.resultSrc = 2'b10; e.PCS = 1'b1;
        put(1'b0, coin(), e);
      end
      default: halt_then_reset(1'b0);
    endcase
  endfunction

  function automatic int wait_len();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAXW + 1)) : int'($urandom_range(0, 2));
  endfunction

  function automatic logic [3:0] pick_cmd();
    case ($urandom_range(0, 5))
      0: return 4'b0100;
      1: return 4'b0010;
      2: return 4'b0000;
      3: return 4'b1100;
      4: return 4'b1010;
      default: return 4'($urandom);
    endcase
  endfunction

  function automatic void build();
    int k;
    cur_op = 2'b00; cur_funct = 6'b0;
    do_reset(2);
    gen(2'b00, 6'b0_0100_1, 0, 0, 1'b0);         // ADD
    gen(2'b01, 6'b1_0100_1, 0, 3, 1'b0);         // LDR with 3 stalls
    gen(2'b01, 6'b1_0100_0, 0, 0, 1'b0);         // STR
    gen(2'b00, 6'b0_1010_0, 0, 0, 1'b0);         // CMP
    gen(2'b10, 6'b101010, 0, 0, 1'b0);
    gen(2'b10, 6'b000000, MAXW, 0, 1'b0);        // ready on the last tolerated cycle
    gen(2'b00, 6'b0_0100_1, MAXW + 1, 0, 1'b0);  // fetch timeout
    gen(2'b01, 6'b0_0000_0, 0, 0, 1'b1);         // reset during store
    gen(2'b01, 6'b0_0000_1, 0, MAXW + 1, 1'b0);  // load timeout
    gen(2'b01, 6'b0_0000_0, 0, MAXW + 1, 1'b0);  // store timeout
    gen(2'b00, 6'b1_1111_0, 0, 0, 1'b0);         // illegal cmd
    gen(2'b11, 6'b000000, 0, 0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 15);
      if (k < 6)
        gen(2'b00, {coin(), pick_cmd(), coin()}, wait_len(), 0, 1'b0);
      else if (k < 11)
        gen(2'b01, 6'($urandom), wait_len(), wait_len(), ($urandom_range(0, 15) == 0));
      else if (k < 15)
        gen(2'b10, 6'($urandom), wait_len(), 0, 1'b0);
      else
        gen(2'b11, 6'($urandom), wait_len(), 0, 1'b0);
    end
  endfunction

  task automatic drive();
    stim_t s;
    logic first = 1'b1;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      if (!first) begin @(posedge clk); #1; end
      first = 1'b0;
      reset = s.rst; memReady = s.rdy; op = s.op; funct = s.funct;
    end
  endtask

  task automatic monitor();
    obs_t got, want;
    int cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got.memReq = memReq; got.adrSrc = adrSrc; got.irWrite = irWrite; got.PCS = PCS;
      got.regW = regW; got.memWriteSrc = memWriteSrc; got.flagUpdate = flagUpdate;
      got.aluSrcA = aluSrcA; got.aluSrcB = aluSrcB; got.aluControl = aluControl;
      got.resultSrc = resultSrc; got.state = state; got.fault = fault;
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: got %h (state %0d fault %b) expected %h (state %0d fault %b)",
                 cyc, got, got.state, got.fault, want, want.state, want.fault);
      end
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; memReady = 1'b0; op = 2'b00; funct = 6'b0;
    build();
    fork
      drive();
      monitor();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
    $fatal(1);
  end

endmodule
